// File: rtl/link_tx_pattern_gen.sv
// Transmit word source for the 8-bit clk160 serial links: training pattern,
// PRBS7 with single-bit error injection, or user payload, plus readback counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | link disabled, IDLE_WORD on the wire, LFSR parked at the seed
// ST_TRAIN | TRAIN_LEN words of TRAIN_WORD for far-end delay/eye lock
// ST_RUN   | word source selected by tx_mode, train_done asserted
module link_tx_pattern_gen #(
  parameter logic [7:0]  TRAIN_WORD = 8'hAA,
  parameter int unsigned TRAIN_LEN  = 64,
  parameter logic [7:0]  IDLE_WORD  = 8'hF0,
  parameter logic [6:0]  PRBS_SEED  = 7'h7F
) (
  input  logic        clk160,
  input  logic        rstb,
  input  logic        tx_enable,
  input  logic [1:0]  tx_mode,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        inject_err,
  input  logic        reset_counters,
  output logic [7:0]  D_IN,
  output logic [1:0]  tx_state,
  output logic        train_done,
  output logic [31:0] word_counter,
  output logic [31:0] err_inj_counter
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [1:0]  MODE_USER  = 2'd0;
  localparam logic [1:0]  MODE_PRBS  = 2'd1;
  localparam logic [1:0]  MODE_TRAIN = 2'd2;
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] train_cnt;
  logic [6:0]  lfsr;
  logic [6:0]  prbs_next;
  logic [7:0]  prbs_out;
  logic [2:0]  inj_sync;
  logic        inj_pending;
  logic        inj_edge;
  logic        inj_fire;
  logic        run_word;
  logic        prbs_word;
  logic        ready_nxt;
  logic        accept;
  logic [7:0]  word_nxt;

  // Eight serial steps of x^7 + x^6 + 1; the first generated bit lands in bit0.
  function automatic logic [14:0] prbs_step8(input logic [6:0] s_in);
    logic [6:0] s;
    logic [7:0] w;
    logic       n;
    s = s_in;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      n    = s[6] ^ s[5];
      s    = {s[5:0], n};
      w[i] = n;
    end
    return {s, w};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tx_enable) state_nxt = ST_TRAIN;
      ST_TRAIN: if (train_cnt == TRAIN_LAST) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!tx_enable) state_nxt = ST_IDLE;
  end

  // A word offered while enable falls or the mode leaves USER is refused,
  // even though data_ready is still high for that one cycle.
  always_comb begin
    run_word  = (state == ST_RUN) && tx_enable;
    prbs_word = run_word && (tx_mode == MODE_PRBS);
    ready_nxt = (state_nxt == ST_RUN) && (tx_mode == MODE_USER);
    accept    = data_valid && data_ready && ready_nxt;
    inj_edge  = (inj_sync == 3'b001);
    inj_fire  = prbs_word && inj_pending;
    {prbs_next, prbs_out} = prbs_step8(lfsr);
  end

  always_comb begin
    word_nxt = IDLE_WORD;
    if (tx_enable) begin
      case (state)
        ST_TRAIN: word_nxt = TRAIN_WORD;
        ST_RUN: begin
          case (tx_mode)
            MODE_USER:  word_nxt = accept ? data_in : IDLE_WORD;
            MODE_PRBS:  word_nxt = prbs_out ^ {7'b0, inj_pending};
            MODE_TRAIN: word_nxt = TRAIN_WORD;
            default:    word_nxt = IDLE_WORD;
          endcase
        end
        default: word_nxt = IDLE_WORD;
      endcase
    end
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_IDLE;
      train_cnt  <= '0;
      D_IN       <= IDLE_WORD;
      data_ready <= 1'b0;
      train_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      train_cnt  <= (state == ST_TRAIN && state_nxt == ST_TRAIN) ? train_cnt + 16'd1 : '0;
      D_IN       <= word_nxt;
      data_ready <= ready_nxt;
      train_done <= (state_nxt == ST_RUN);
    end
  end

  // Any cycle that does not emit a PRBS word parks the LFSR on the seed.
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      lfsr        <= PRBS_SEED;
      inj_sync    <= '0;
      inj_pending <= 1'b0;
    end else begin
      lfsr     <= prbs_word ? prbs_next : PRBS_SEED;
      inj_sync <= {inj_sync[1:0], inject_err};
      if (state_nxt == ST_IDLE) begin
        inj_pending <= 1'b0;
      end else if (inj_fire) begin
        inj_pending <= 1'b0;
      end else if (inj_edge) begin
        inj_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      word_counter    <= '0;
      err_inj_counter <= '0;
    end else if (reset_counters) begin
      word_counter    <= '0;
      err_inj_counter <= '0;
    end else begin
      if (run_word && word_counter != 32'hFFFF_FFFF) begin
        word_counter <= word_counter + 32'd1;
      end
      if (inj_fire && err_inj_counter != 32'hFFFF_FFFF) begin
        err_inj_counter <= err_inj_counter + 32'd1;
      end
    end
  end

  assign tx_state = state;

endmodule

// File: doc/link_tx_pattern_gen.md
Name: link_tx_pattern_gen

Overview:
Transmit-side word source for the 8-bit-per-clk160 serial links. It drives the parallel word into the OSERDES and supplies what the far-end delay/eye-scan logic needs to lock:
- a fixed training pattern after enable;
- PRBS7 for BER and eye scans, with optional single-bit error injection;
- user payload from an upstream FIFO through a valid/ready handshake.

It also keeps saturating word and injected-error counters for register readback.

Parameters:
TRAIN_WORD, 8'hAA, word sent during TRAIN; alternating bits give a transition every bit.
TRAIN_LEN, 64, number of TRAIN words per enable, range 1..65535.
IDLE_WORD, 8'hF0, word sent in IDLE and in USER mode when no data is accepted.
PRBS_SEED, 7'h7F, LFSR load value; must be nonzero.

Ports:
clk160  input  1  word clock; all logic is on the rising edge.
rstb  input  1  asynchronous active-low reset.
tx_enable  input  1  level; 1 = run the TRAIN then RUN sequence.
tx_mode  input  2  RUN source: 0 = USER, 1 = PRBS7, 2 = TRAIN_WORD continuous, 3 = IDLE_WORD.
data_in  input  8  user word; bit0 is serialised first.
data_valid  input  1  user word valid.
data_ready  output  1  block accepts data_in this cycle.
inject_err  input  1  async-domain request; the rising edge is detected after sync.
reset_counters  input  1  level; clears both counters.
D_IN  output  8  word to OSERDES; bit0 is first in time.
tx_state  output  2  0 = IDLE, 1 = TRAIN, 2 = RUN.
train_done  output  1  1 while in RUN.
word_counter  output  32  words sent in RUN, saturating.
err_inj_counter  output  32  errors injected, saturating.

Behaviour:
Reset (rstb low, asynchronous) sets:
- D_IN = IDLE_WORD, data_ready = 0, tx_state = IDLE, train_done = 0;
- both counters = 0;
- LFSR = PRBS_SEED;
- train count = 0, inject sync register = 0.

All outputs are registered. D_IN has a 1-cycle latency from the selection or handshake cycle.

State machine:
- IDLE:
  - D_IN = IDLE_WORD; LFSR held at PRBS_SEED.
  - tx_enable = 1 → go to TRAIN and clear the train count.
- TRAIN:
  - D_IN = TRAIN_WORD each cycle; the count increments.
  - After TRAIN_LEN words → go to RUN.
  - A TRAIN_LEN-word run is exactly TRAIN_LEN consecutive D_IN = TRAIN_WORD cycles.
- RUN:
  - Output follows tx_mode; train_done = 1.
- Any state with tx_enable = 0 → IDLE on the next edge; D_IN = IDLE_WORD from the following cycle.
- Re-enabling always restarts TRAIN.
- Unused encoding 3 → IDLE.

PRBS7:
- Polynomial x^7 + x^6 + 1.
- Per serial bit: n = s[6] ^ s[5]; s <= {s[5:0], n}; the output bit is n.
- Eight steps per clock, mapped to bits 0..7.
- The LFSR advances only while in RUN with tx_mode = 1.
- It reloads PRBS_SEED in any cycle where it is not in RUN or tx_mode != 1, so every entry into PRBS starts from the seed.
- First word from PRBS_SEED = 7'h7F is 8'h40; LFSR afterwards is 7'h02.

Error injection:
- inject_err passes through a 3-bit shift register; the rising edge is detected on pattern 3'b001.
- An edge arms a pending flag.
- The next PRBS word is sent with bit0 inverted; the flag clears and err_inj_counter increments.
- The LFSR sequence is unaffected: only the output word is flipped.
- Edges outside PRBS mode stay pending until a PRBS word is sent.
- An edge arriving while already pending is dropped: at most one pending injection.
- Pending clears on entering IDLE.

USER mode:
- data_ready = 1 exactly when the next state is RUN with tx_mode = 0. It is registered, so it is valid in the cycle it is observed.
- Handshake: data_valid && data_ready → D_IN = data_in on the next cycle; otherwise D_IN = IDLE_WORD.
- No buffering; the source must hold data_in until accepted.
- data_ready drops in the same edge that tx_enable falls or the mode changes are registered. A word offered in that cycle is not taken.

Counters:
- word_counter increments for every word sent in RUN, in any mode.
- Both counters saturate at 32'hFFFFFFFF.
- reset_counters = 1 clears both, with priority over increment.

Test Plan:
1. Reset, then tx_enable = 1 with tx_mode = 1 and TRAIN_LEN = 4 → D_IN = 8'hF0 during IDLE, then exactly 4 × 8'hAA, tx_state goes 1 → 2, first PRBS word is 8'h40.
2. PRBS run of 127 words versus a reference serial LFSR model → all 1016 bits match and the sequence repeats with period 127 bits; word_counter = 127.
3. Pulse inject_err during PRBS → exactly one later word differs in bit0 only; err_inj_counter = 1; the following words match the model. A second edge while pending → err_inj_counter still 1.
4. USER mode with data_valid toggling and data_in = 8'h11, 8'h22, 8'h33 → D_IN shows those words one cycle after each accepted handshake and 8'hF0 in gap cycles; data_ready = 0 during TRAIN.
5. Drop tx_enable mid-PRBS, then re-enable → IDLE_WORD appears, TRAIN repeats, first PRBS word is again 8'h40; pending injection is cleared.
6. Preload word_counter near saturation, or force it, and hold RUN → it sticks at 32'hFFFFFFFF. Assert reset_counters → 0 the next cycle. Assert rstb low asynchronously mid-TRAIN → all outputs reach reset values without a clock.
